// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle: ID/EX/MEM status into the controller, stall/flush/divider control out.
interface pipe_hazard_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_uses_rs;
  logic       ID_uses_rt;
  logic       EX_memread;
  logic [4:0] EX_wreg;
  logic       ID_div_start;
  logic       ID_hilo_use;
  logic       EX_branch_taken;
  logic       exc_req;
  logic       PCWrite;
  logic       IFID_flush;
  logic       IDEX_flush;
  logic       div_busy;
  logic       div_abort;
  logic [1:0] state;

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_memread, EX_wreg,
    output ID_div_start, ID_hilo_use, EX_branch_taken, exc_req,
    input  PCWrite, IFID_flush, IDEX_flush, div_busy, div_abort, state
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_memread, EX_wreg,
    input  ID_div_start, ID_hilo_use, EX_branch_taken, exc_req,
    output PCWrite, IFID_flush, IDEX_flush, div_busy, div_abort, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch/exception flushes,
// and tracking of the multi-cycle divider occupancy.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic         cpu_clk,
  input  logic         reset,
  pipe_hazard_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_DIV = 2'd1,
    ST_EXC = 2'd2
  } state_t;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 32'd1);

  state_t     state_r;
  state_t     state_s;
  logic [5:0] cnt_r;
  logic [5:0] cnt_s;
  logic       div_busy_r;
  logic       pc_write_s;
  logic       ifid_flush_s;
  logic       idex_flush_s;
  logic       div_abort_s;
  logic       load_use_s;
  logic       hilo_haz_s;

  assign load_use_s = hz.EX_memread && (hz.EX_wreg != 5'd0) &&
                      ((hz.ID_uses_rs && (hz.ID_rs == hz.EX_wreg)) ||
                       (hz.ID_uses_rt && (hz.ID_rt == hz.EX_wreg)));

  // A second div while busy is covered here because div also raises ID_hilo_use.
  assign hilo_haz_s = (state_r == ST_DIV) && hz.ID_hilo_use;

  // Next-state and same-cycle stall/flush decisions, highest priority first.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pc_write_s   = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    div_abort_s  = 1'b0;
    if (reset) begin
      state_s = ST_RUN;
      cnt_s   = 6'd0;
    end else if (hz.exc_req) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
      div_abort_s  = (state_r == ST_DIV);
      state_s      = ST_EXC;
      cnt_s        = 6'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hz.EX_branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_write_s   = 1'b0;
            idex_flush_s = 1'b1;
          end else if (hz.ID_div_start) begin
            state_s = ST_DIV;
            cnt_s   = CNT_LOAD;
          end else begin
            pc_write_s = 1'b1;
          end
        end
        ST_DIV: begin
          // The divide is older than any branch, so it keeps counting regardless.
          if (hz.EX_branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (hilo_haz_s || load_use_s) begin
            pc_write_s   = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_write_s = 1'b1;
          end
          if (cnt_r == 6'd0) begin
            state_s = ST_RUN;
          end else begin
            cnt_s = cnt_r - 6'd1;
          end
        end
        ST_EXC: begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          state_s      = ST_RUN;
        end
        default: begin
          state_s = ST_RUN;
          cnt_s   = 6'd0;
        end
      endcase
    end
  end

  // State, divider counter and busy flag register.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_r    <= ST_RUN;
      cnt_r      <= 6'd0;
      div_busy_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_busy_r <= (state_s == ST_DIV);
    end
  end

  assign hz.PCWrite    = pc_write_s;
  assign hz.IFID_flush = ifid_flush_s;
  assign hz.IDEX_flush = idex_flush_s;
  assign hz.div_abort  = div_abort_s;
  assign hz.div_busy   = div_busy_r;
  assign hz.state      = state_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle scoreboard plus directed scenario checks.
module tb_pipe_hazard_ctrl;

  localparam int DIV_CYCLES = 32;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       idex;
    logic       abort;
    logic       busy;
    logic [1:0] st;
  } exp_t;

  logic cpu_clk = 1'b0;
  logic reset;
  pipe_hazard_if hz();

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .hz      (hz)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  exp_t mon_exp;
  exp_t mon_got;
  logic [1:0] m_state = 2'd0;
  int m_cnt = 0;
  int cyc = 0;

  logic [4:0] s_rs, s_rt, s_wreg;
  logic s_uses_rs, s_uses_rt, s_memread, s_div, s_hilo, s_branch, s_exc, s_reset;

  task automatic clear_inputs();
    s_rs = 5'd0; s_rt = 5'd0; s_wreg = 5'd0;
    s_uses_rs = 1'b0; s_uses_rt = 1'b0; s_memread = 1'b0;
    s_div = 1'b0; s_hilo = 1'b0; s_branch = 1'b0; s_exc = 1'b0; s_reset = 1'b0;
  endtask

  task automatic drive_inputs();
    hz.ID_rs = s_rs; hz.ID_rt = s_rt; hz.EX_wreg = s_wreg;
    hz.ID_uses_rs = s_uses_rs; hz.ID_uses_rt = s_uses_rt; hz.EX_memread = s_memread;
    hz.ID_div_start = s_div; hz.ID_hilo_use = s_hilo;
    hz.EX_branch_taken = s_branch; hz.exc_req = s_exc; reset = s_reset;
  endtask

  // One clock: drive staged inputs after the edge, push the expected result, update the model.
  task automatic cycle();
    exp_t e;
    logic lu;
    logic [1:0] nst;
    int ncnt;
    @(posedge cpu_clk);
    #1;
    drive_inputs();
    lu = s_memread && (s_wreg != 5'd0) &&
         ((s_uses_rs && (s_rs == s_wreg)) || (s_uses_rt && (s_rt == s_wreg)));
    e.pc = 1'b1; e.ifid = 1'b0; e.idex = 1'b0; e.abort = 1'b0;
    e.busy = (m_state == 2'd1); e.st = m_state;
    nst = m_state; ncnt = m_cnt;
    if (s_reset) begin
      nst = 2'd0; ncnt = 0;
    end else if (s_exc) begin
      e.ifid = 1'b1; e.idex = 1'b1; e.abort = (m_state == 2'd1);
      nst = 2'd2; ncnt = 0;
    end else begin
      if (m_state == 2'd2 || s_branch) begin
        e.ifid = 1'b1; e.idex = 1'b1;
      end else if ((m_state == 2'd1 && s_hilo) || lu) begin
        e.pc = 1'b0; e.idex = 1'b1;
      end
      if (m_state == 2'd2) nst = 2'd0;
      else if (m_state == 2'd1) begin
        if (m_cnt == 0) nst = 2'd0;
        else ncnt = m_cnt - 1;
      end else if (s_div && !s_branch && !lu) begin
        nst = 2'd1; ncnt = DIV_CYCLES - 1;
      end
    end
    sb_q.push_back(e);
    m_state = nst;
    m_cnt = ncnt;
    cyc++;
    @(negedge cpu_clk);
    #3;
  endtask

  // Scoreboard consumer: compares every cycle's outputs midway between edges.
  always @(negedge cpu_clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_got = {hz.PCWrite, hz.IFID_flush, hz.IDEX_flush, hz.div_abort, hz.div_busy, hz.state};
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_errors++;
        $display("FAIL scoreboard cyc=%0d got pc/ifid/idex/abort/busy/st=%b expected %b",
                 cyc, mon_got, mon_exp);
      end
    end
  end

  task automatic test_reset();
    clear_inputs();
    s_reset = 1'b1; s_exc = 1'b1; s_branch = 1'b1; s_memread = 1'b1;
    s_wreg = 5'd3; s_rs = 5'd3; s_uses_rs = 1'b1; s_div = 1'b1; s_hilo = 1'b1;
    cycle();
    n_checks++;
    if (hz.PCWrite !== 1'b1 || hz.IFID_flush !== 1'b0 || hz.IDEX_flush !== 1'b0 || hz.div_abort !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs got %b%b%b%b expected 1000", hz.PCWrite, hz.IFID_flush, hz.IDEX_flush, hz.div_abort);
    end
    cycle();
    clear_inputs();
    cycle();
    n_checks++;
    if (hz.state !== 2'd0 || hz.div_busy !== 1'b0 || hz.PCWrite !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state got st=%0d busy=%b pc=%b expected 0 0 1", hz.state, hz.div_busy, hz.PCWrite);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    s_memread = 1'b1; s_wreg = 5'd5; s_rs = 5'd5; s_uses_rs = 1'b1;
    cycle();
    n_checks++;
    if (hz.PCWrite !== 1'b0 || hz.IDEX_flush !== 1'b1 || hz.IFID_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_stall got pc=%b idex=%b ifid=%b expected 0 1 0", hz.PCWrite, hz.IDEX_flush, hz.IFID_flush);
    end
    s_memread = 1'b0;
    cycle();
    n_checks++;
    if (hz.PCWrite !== 1'b1 || hz.IDEX_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_release got pc=%b idex=%b expected 1 0", hz.PCWrite, hz.IDEX_flush);
    end
    s_memread = 1'b1; s_wreg = 5'd0; s_rs = 5'd0;
    cycle();
    n_checks++;
    if (hz.PCWrite !== 1'b1) begin
      n_errors++;
      $display("FAIL load_use_r0 got pc=%b expected 1", hz.PCWrite);
    end
    s_wreg = 5'd7; s_rs = 5'd1; s_rt = 5'd7; s_uses_rt = 1'b0;
    cycle();
    s_uses_rt = 1'b1;
    cycle();
    n_checks++;
    if (hz.PCWrite !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_rt got pc=%b expected 0", hz.PCWrite);
    end
    clear_inputs();
  endtask

  task automatic test_divide();
    int busy_n;
    int stall_n;
    clear_inputs();
    s_div = 1'b1; s_hilo = 1'b1;
    cycle();
    clear_inputs();
    busy_n = 0; stall_n = 0;
    for (int i = 0; i < 40; i++) begin
      s_hilo = (i >= 4);
      cycle();
      if (hz.div_busy === 1'b1) busy_n++;
      if (hz.PCWrite === 1'b0) stall_n++;
      if (hz.state === 2'd0) break;
    end
    n_checks++;
    if (busy_n != DIV_CYCLES || stall_n != DIV_CYCLES - 4) begin
      n_errors++;
      $display("FAIL divide_length got busy=%0d stall=%0d expected %0d %0d", busy_n, stall_n, DIV_CYCLES, DIV_CYCLES - 4);
    end
    n_checks++;
    if (hz.state !== 2'd0 || hz.PCWrite !== 1'b1) begin
      n_errors++;
      $display("FAIL divide_mflo_accept got st=%0d pc=%b expected 0 1", hz.state, hz.PCWrite);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    s_memread = 1'b1; s_wreg = 5'd5; s_rs = 5'd5; s_uses_rs = 1'b1; s_branch = 1'b1;
    cycle();
    n_checks++;
    if (hz.PCWrite !== 1'b1 || hz.IFID_flush !== 1'b1 || hz.IDEX_flush !== 1'b1) begin
      n_errors++;
      $display("FAIL branch_over_stall got %b%b%b expected 111", hz.PCWrite, hz.IFID_flush, hz.IDEX_flush);
    end
    clear_inputs();
    s_div = 1'b1; s_hilo = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    s_branch = 1'b1;
    cycle();
    n_checks++;
    if (hz.div_abort !== 1'b0 || hz.div_busy !== 1'b1 || hz.IFID_flush !== 1'b1) begin
      n_errors++;
      $display("FAIL branch_in_div got abort=%b busy=%b ifid=%b expected 0 1 1", hz.div_abort, hz.div_busy, hz.IFID_flush);
    end
    s_branch = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (hz.state === 2'd0) break;
    end
    n_checks++;
    if (hz.state !== 2'd0) begin
      n_errors++;
      $display("FAIL branch_div_finish got st=%0d expected 0", hz.state);
    end
  endtask

  task automatic test_exc_in_div();
    clear_inputs();
    s_div = 1'b1; s_hilo = 1'b1;
    cycle();
    clear_inputs();
    for (int i = 0; i < 21; i++) cycle();
    s_exc = 1'b1;
    cycle();
    n_checks++;
    if (hz.div_abort !== 1'b1 || hz.IFID_flush !== 1'b1 || hz.IDEX_flush !== 1'b1 || hz.state !== 2'd1) begin
      n_errors++;
      $display("FAIL exc_div_abort got abort=%b ifid=%b idex=%b st=%0d expected 1 1 1 1",
               hz.div_abort, hz.IFID_flush, hz.IDEX_flush, hz.state);
    end
    s_exc = 1'b0;
    cycle();
    n_checks++;
    if (hz.state !== 2'd2 || hz.div_busy !== 1'b0 || hz.IFID_flush !== 1'b1 || hz.div_abort !== 1'b0) begin
      n_errors++;
      $display("FAIL exc_state got st=%0d busy=%b ifid=%b abort=%b expected 2 0 1 0",
               hz.state, hz.div_busy, hz.IFID_flush, hz.div_abort);
    end
    cycle();
    n_checks++;
    if (hz.state !== 2'd0 || hz.div_busy !== 1'b0 || hz.IFID_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL exc_return got st=%0d busy=%b ifid=%b expected 0 0 0", hz.state, hz.div_busy, hz.IFID_flush);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want_st [5];
    want_st = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      s_exc = (i < 3);
      cycle();
      n_checks++;
      if (hz.state !== want_st[i] || hz.IFID_flush !== (i < 4) || hz.IDEX_flush !== (i < 4)) begin
        n_errors++;
        $display("FAIL exc_b2b[%0d] got st=%0d ifid=%b idex=%b expected %0d %b %b",
                 i, hz.state, hz.IFID_flush, hz.IDEX_flush, want_st[i], (i < 4), (i < 4));
      end
    end
    // A div held through the whole divide stalls every DIV cycle and issues in RUN.
    clear_inputs();
    s_div = 1'b1; s_hilo = 1'b1;
    cycle();
    for (int i = 0; i < DIV_CYCLES; i++) cycle();
    cycle();
    n_checks++;
    if (hz.state !== 2'd0 || hz.PCWrite !== 1'b1) begin
      n_errors++;
      $display("FAIL div_reissue got st=%0d pc=%b expected 0 1", hz.state, hz.PCWrite);
    end
    clear_inputs();
    cycle();
    n_checks++;
    if (hz.state !== 2'd1 || hz.div_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL div_reissue_busy got st=%0d busy=%b expected 1 1", hz.state, hz.div_busy);
    end
    s_reset = 1'b1;
    cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_div();
    clear_inputs();
    s_div = 1'b1; s_hilo = 1'b1;
    cycle();
    clear_inputs();
    for (int i = 0; i < 11; i++) cycle();
    s_reset = 1'b1; s_exc = 1'b1;
    cycle();
    n_checks++;
    if (hz.div_abort !== 1'b0 || hz.PCWrite !== 1'b1 || hz.IFID_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_div_abort got abort=%b pc=%b ifid=%b expected 0 1 0", hz.div_abort, hz.PCWrite, hz.IFID_flush);
    end
    clear_inputs();
    cycle();
    n_checks++;
    if (hz.state !== 2'd0 || hz.div_busy !== 1'b0 || hz.PCWrite !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_div_state got st=%0d busy=%b pc=%b expected 0 0 1", hz.state, hz.div_busy, hz.PCWrite);
    end
    s_exc = 1'b1;
    cycle();
    s_exc = 1'b0; s_reset = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    n_checks++;
    if (hz.state !== 2'd0 || hz.IFID_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_exc got st=%0d ifid=%b expected 0 0", hz.state, hz.IFID_flush);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s_rs = 5'($urandom_range(0, 3)); s_rt = 5'($urandom_range(0, 3)); s_wreg = 5'($urandom_range(0, 3));
      s_uses_rs = 1'($urandom_range(0, 1)); s_uses_rt = 1'($urandom_range(0, 1));
      s_memread = ($urandom_range(0, 3) == 0);
      s_div = ($urandom_range(0, 7) == 0);
      s_hilo = s_div || ($urandom_range(0, 3) == 0);
      s_branch = ($urandom_range(0, 9) == 0);
      s_exc = ($urandom_range(0, 29) == 0);
      s_reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear_inputs();
    cycle();
  endtask

  initial begin
    clear_inputs();
    s_reset = 1'b1;
    drive_inputs();
    repeat (2) @(posedge cpu_clk);
    test_reset();
    test_load_use();
    test_divide();
    test_branch();
    test_exc_in_div();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
